// File: rtl/sram_responder.sv
// Wait-state SRAM responder on the 16-bit SRAM pin bus.
// Delays reads and writes by a programmable number of cycles.
module sram_responder #(
  parameter int MEM_AW     = 12,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SRAMaddress,
  input  logic        SRAMWEn,
  inout  wire  [15:0] SRAMdata,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_VALID,
    WR_WAIT,
    WR_DONE
  } state_t;

  localparam logic [3:0] RD_INIT = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_INIT = 4'(WRITE_WAIT - 1);

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [17:0] addr_q;
  logic wen_q;
  logic v_q;
  logic [15:0] rd_data;
  logic [15:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic new_acc;
  logic mem_we;
  logic rd_load;
  logic rd_inc;
  logic wr_inc;

  assign idx = SRAMaddress[MEM_AW-1:0];

  // Only address/direction changes start an access; data wiggle does not.
  assign new_acc = !v_q
                 || (SRAMaddress != addr_q)
                 || (SRAMWEn != wen_q);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mem_we  = 1'b0;
    rd_load = 1'b0;
    rd_inc  = 1'b0;
    wr_inc  = 1'b0;
    if (new_acc) begin
      if (SRAMWEn) begin
        if (READ_WAIT == 0) begin
          state_d = RD_VALID;
          rd_load = 1'b1;
          rd_inc  = 1'b1;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = RD_INIT;
        end
      end else begin
        if (WRITE_WAIT == 0) begin
          state_d = WR_DONE;
          mem_we  = 1'b1;
          wr_inc  = 1'b1;
        end else begin
          state_d = WR_WAIT;
          cnt_d   = WR_INIT;
        end
      end
    end else begin
      case (state)
        RD_WAIT: begin
          if (cnt == 4'd0) begin
            state_d = RD_VALID;
            rd_load = 1'b1;
            rd_inc  = 1'b1;
          end else begin
            cnt_d = cnt - 4'd1;
          end
        end
        WR_WAIT: begin
          if (cnt == 4'd0) begin
            state_d = WR_DONE;
            mem_we  = 1'b1;
            wr_inc  = 1'b1;
          end else begin
            cnt_d = cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      v_q      <= 1'b0;
      addr_q   <= 18'd0;
      wen_q    <= 1'b1;
      rd_data  <= 16'd0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      v_q    <= 1'b1;
      addr_q <= SRAMaddress;
      wen_q  <= SRAMWEn;
      if (rd_load) begin
        rd_data <= mem[idx];
      end
      if (rd_inc && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
      if (wr_inc && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx] <= SRAMdata;
    end
  end

  assign busy = (state == RD_WAIT) || (state == WR_WAIT);

  // WEn gate is combinational so the bus frees the cycle WEn drops.
  assign SRAMdata = ((state == RD_VALID) && SRAMWEn) ? rd_data : 16'bz;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed table, random vs. timing model,
// and zero-wait counter saturation.
module tb_sram_responder;

  localparam int R = 2;
  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        wen = 1'b1;
  logic [17:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        drive = 1'b0;
  wire  [15:0] bus;
  logic        busy;
  logic [15:0] rdc, wrc;

  assign bus = drive ? wdata : 16'bz;

  logic        rst0 = 1'b1;
  logic        wen0 = 1'b1;
  logic [17:0] addr0 = '0;
  logic [15:0] wdata0 = '0;
  logic        drive0 = 1'b0;
  wire  [15:0] bus0;
  logic        busy0;
  logic [15:0] rdc0, wrc0;

  assign bus0 = drive0 ? wdata0 : 16'bz;

  sram_responder #(.MEM_AW(12), .READ_WAIT(R), .WRITE_WAIT(W)) dut (
    .clk(clk), .rst(rst), .SRAMaddress(addr), .SRAMWEn(wen),
    .SRAMdata(bus), .busy(busy), .rd_count(rdc), .wr_count(wrc)
  );

  sram_responder #(.MEM_AW(12), .READ_WAIT(0), .WRITE_WAIT(0)) dut0 (
    .clk(clk), .rst(rst0), .SRAMaddress(addr0), .SRAMWEn(wen0),
    .SRAMdata(bus0), .busy(busy0), .rd_count(rdc0), .wr_count(wrc0)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // An undriven net reads as Z, or as 0 in a two-state simulator.
  task automatic chk_rel(string name, logic [15:0] act);
    checks++;
    if (act === 16'hzzzz || act === 16'h0000) passed++;
    else $display("FAIL %s: got %h expected released bus", name, act);
  endtask

  typedef struct {
    logic        r;
    logic        we_n;
    logic [17:0] a;
    logic [15:0] d;
    logic        b;
    int          bm;
    logic [15:0] bv;
    logic [15:0] rc;
    logic [15:0] wc;
  } vec_t;

  function automatic vec_t v(logic r, logic we_n, logic [17:0] a,
                             logic [15:0] d, logic b, int bm,
                             logic [15:0] bv, logic [15:0] rc,
                             logic [15:0] wc);
    vec_t x;
    x.r = r; x.we_n = we_n; x.a = a; x.d = d; x.b = b;
    x.bm = bm; x.bv = bv; x.rc = rc; x.wc = wc;
    return x;
  endfunction

  // Timing model: an access started at edge e0 resolves at e0+wait.
  logic [15:0] mm [4096];
  bit          mk [4096];
  bit          m_started, m_idle;
  logic [17:0] m_pa;
  logic        m_pw;
  int          el;
  logic [15:0] m_rv;
  bit          m_rk;
  int          m_rc, m_wc;

  task automatic model_edge();
    int i;
    if (rst) begin
      m_started = 0; m_idle = 1; m_rc = 0; m_wc = 0; el = 0;
      return;
    end
    if (!m_started || addr != m_pa || wen != m_pw) begin
      el = 0;
      m_idle = 0;
    end else if (el < 1000) begin
      el++;
    end
    m_started = 1; m_pa = addr; m_pw = wen;
    i = int'(addr[11:0]);
    if (!wen && el == W) begin
      mm[i] = wdata; mk[i] = 1;
      if (m_wc < 65535) m_wc++;
    end
    if (wen && el == R) begin
      m_rv = mm[i]; m_rk = mk[i];
      if (m_rc < 65535) m_rc++;
    end
  endtask

  initial begin
    vec_t tbl[$];
    logic [15:0] e;

    // Write 5, read 5, aborted write to 0x10, alias, reset mid-read.
    tbl.push_back(v(1, 1, 18'h00000, 16'h0000, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 18'h00005, 16'hBEEF, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 18'h00005, 16'hBEEF, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 18'h00005, 16'hBEEF, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 18'h00005, 16'h0000, 1, 1, 0, 0, 1));
    tbl.push_back(v(0, 1, 18'h00005, 16'h0000, 1, 1, 0, 0, 1));
    tbl.push_back(v(0, 1, 18'h00005, 16'h0000, 0, 2, 16'hBEEF, 1, 1));
    tbl.push_back(v(0, 1, 18'h00005, 16'h0000, 0, 2, 16'hBEEF, 1, 1));
    tbl.push_back(v(0, 0, 18'h00010, 16'h2222, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 18'h00010, 16'h2222, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 18'h00010, 16'h2222, 0, 0, 0, 1, 2));
    tbl.push_back(v(0, 1, 18'h00010, 16'h0000, 1, 1, 0, 1, 2));
    tbl.push_back(v(0, 1, 18'h00010, 16'h0000, 1, 1, 0, 1, 2));
    tbl.push_back(v(0, 1, 18'h00010, 16'h0000, 0, 2, 16'h2222, 2, 2));
    tbl.push_back(v(0, 0, 18'h00010, 16'h1111, 1, 0, 0, 2, 2));
    tbl.push_back(v(0, 0, 18'h00011, 16'h1111, 1, 0, 0, 2, 2));
    tbl.push_back(v(0, 1, 18'h00010, 16'h0000, 1, 1, 0, 2, 2));
    tbl.push_back(v(0, 1, 18'h00010, 16'h0000, 1, 1, 0, 2, 2));
    tbl.push_back(v(0, 1, 18'h00010, 16'h0000, 0, 2, 16'h2222, 3, 2));
    tbl.push_back(v(0, 0, 18'h01003, 16'h1234, 1, 0, 0, 3, 2));
    tbl.push_back(v(0, 0, 18'h01003, 16'h1234, 1, 0, 0, 3, 2));
    tbl.push_back(v(0, 0, 18'h01003, 16'h1234, 0, 0, 0, 3, 3));
    tbl.push_back(v(0, 1, 18'h00003, 16'h0000, 1, 1, 0, 3, 3));
    tbl.push_back(v(0, 1, 18'h00003, 16'h0000, 1, 1, 0, 3, 3));
    tbl.push_back(v(0, 1, 18'h00003, 16'h0000, 0, 2, 16'h1234, 4, 3));
    tbl.push_back(v(0, 1, 18'h00005, 16'h0000, 1, 1, 0, 4, 3));
    tbl.push_back(v(1, 1, 18'h00005, 16'h0000, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 18'h00005, 16'h0000, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 18'h00005, 16'h0000, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 18'h00005, 16'h0000, 0, 2, 16'hBEEF, 1, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      wen = tbl[i].we_n;
      addr = tbl[i].a;
      wdata = tbl[i].d;
      drive = !tbl[i].we_n;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("vec%0d rd_count", i), 32'(rdc), 32'(tbl[i].rc));
      chk($sformatf("vec%0d wr_count", i), 32'(wrc), 32'(tbl[i].wc));
      if (tbl[i].bm == 1) chk_rel($sformatf("vec%0d bus", i), bus);
      if (tbl[i].bm == 2)
        chk($sformatf("vec%0d data", i), 32'(bus), 32'(tbl[i].bv));
    end

    // Randomised accesses against the timing model.
    for (int i = 0; i < 4096; i++) mk[i] = 0;
    rst = 1; wen = 1; drive = 0;
    @(posedge clk); model_edge();
    @(negedge clk);
    rst = 0;
    for (int s = 0; s < 120; s++) begin
      logic [17:0] a;
      logic        w;
      int          h;
      a = {6'($urandom_range(0, 3)), 9'd0, 3'($urandom_range(0, 7))};
      w = 1'($urandom_range(0, 1));
      h = $urandom_range(1, 5);
      for (int c = 0; c < h; c++) begin
        addr = a; wen = w; wdata = 16'($urandom); drive = !w;
        @(posedge clk); model_edge();
        @(negedge clk);
        chk("rand busy", 32'(busy),
            32'(!m_idle && el < (m_pw ? R : W)));
        chk("rand rd_count", 32'(rdc), 32'(m_rc));
        chk("rand wr_count", 32'(wrc), 32'(m_wc));
        if (wen && !m_idle && el >= R) begin
          if (m_rk) chk("rand data", 32'(bus), 32'(m_rv));
        end else if (wen) begin
          chk_rel("rand bus", bus);
        end
      end
    end

    // Zero-wait instance: one access per cycle, counter saturation.
    rst0 = 1;
    @(posedge clk);
    @(negedge clk);
    rst0 = 0;
    for (int i = 0; i < 64; i++) begin
      addr0 = 18'(i); wen0 = 0; drive0 = 1;
      wdata0 = 16'(i * 257 + 16'h5A00);
      @(posedge clk);
      @(negedge clk);
      chk("zw wr_count", 32'(wrc0), 32'(i + 1));
      chk("zw busy", 32'(busy0), 0);
    end
    drive0 = 0; wen0 = 1;
    for (int k = 1; k <= 65537; k++) begin
      addr0 = 18'((k - 1) % 64);
      @(posedge clk);
      @(negedge clk);
      if (k <= 128) begin
        e = 16'(((k - 1) % 64) * 257 + 16'h5A00);
        chk("zw data", 32'(bus0), 32'(e));
        chk("zw rd_count", 32'(rdc0), 32'(k));
      end
      if (k >= 65534)
        chk("zw rd_sat", 32'(rdc0), 32'(k > 65535 ? 65535 : k));
    end
    chk("zw wr_hold", 32'(wrc0), 64);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
